cordic_gain_comp: RTL



---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_gain_comp_shift_add_mul.sv | 44 ++++
 rtl/cordic_gain_comp.sv | 101 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the 16-bit vectoring CORDIC and its consumers.
package cordic_pkg;

  localparam int unsigned CORDIC_W     = 16;
  localparam int unsigned CORDIC_XW    = 18;
  localparam int unsigned CORDIC_K_Q16 = 39797;
  localparam int unsigned CORDIC_ACC_W = 34;

  typedef struct packed {
    logic signed [CORDIC_XW-1:0] x;
    logic signed [CORDIC_W-1:0]  y;
    logic signed [CORDIC_W-1:0]  z;
  } cordic_vec_resp_t;

  typedef struct packed {
    logic [16:0]         mag;
    logic [CORDIC_W-1:0] phase;
  } cordic_polar_t;

  typedef enum logic [1:0] {
    GC_IDLE,
    GC_MUL,
    GC_FIN,
    GC_DONE
  } gc_state_t;

endpackage

// File: rtl/cordic_gain_comp_shift_add_mul.sv
// Unsigned sequential shift-add multiplier: one multiplier bit consumed per step.
module shift_add_mul #(
  parameter int unsigned A_W = 34,
  parameter int unsigned B_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [A_W-1:0] mcand_in,
  input  logic [B_W-1:0] mult_in,
  output logic           last,
  output logic [A_W-1:0] acc
);

  localparam int unsigned CNT_W = $clog2(B_W + 1);

  logic [A_W-1:0]   mcand;
  logic [B_W-1:0]   mult;
  logic [CNT_W-1:0] cnt;

  // High while the step that performs the final add is in progress.
  assign last = (cnt == CNT_W'(B_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= mcand_in;
      mult  <= mult_in;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      if (mult[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC gain removal: magnitude = x*K (Q0.16), phase pass-through, put/get handshakes.
// Define CORDIC_GAIN_ROUND_EN for round-half-up instead of truncation.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int unsigned K_Q16  = CORDIC_K_Q16,
  parameter int unsigned K_BITS = CORDIC_W
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [49:0] request_put,
  input  logic        EN_request_put,
  output logic        RDY_request_put,
  output logic [32:0] response_get,
  input  logic        EN_response_get,
  output logic        RDY_response_get
);

  localparam int unsigned ACC_W = CORDIC_ACC_W;
`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(32'h8000);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  cordic_vec_resp_t req;
  cordic_polar_t    resp;
  gc_state_t        state, state_nx;
  logic [CORDIC_W-1:0] phase_r;
  logic [ACC_W-1:0]    mcand_in, acc, rounded;
  logic                mul_start, mul_step, mul_last, resp_load;
  logic                unused_bits;

  assign req = request_put;

  // Negative residuals are clamped to zero magnitude.
  assign mcand_in = req.x[CORDIC_XW-1] ? '0
                  : {{(ACC_W-CORDIC_XW){1'b0}}, req.x};
  assign rounded  = acc + RND;
  assign unused_bits = ^{req.y, rounded[ACC_W-1], rounded[15:0]};

  shift_add_mul #(
    .A_W (ACC_W),
    .B_W (K_BITS)
  ) u_mul (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (mul_start),
    .step     (mul_step),
    .mcand_in (mcand_in),
    .mult_in  (K_BITS'(K_Q16)),
    .last     (mul_last),
    .acc      (acc)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= GC_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    resp_load = 1'b0;
    unique case (state)
      GC_IDLE: if (EN_request_put) begin
        mul_start = 1'b1;
        state_nx  = GC_MUL;
      end
      GC_MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_nx = GC_FIN;
      end
      GC_FIN: begin
        resp_load = 1'b1;
        state_nx  = GC_DONE;
      end
      GC_DONE: if (EN_response_get) state_nx = GC_IDLE;
      default: state_nx = GC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_r <= '0;
      resp    <= '0;
    end else begin
      if (mul_start) phase_r <= req.z;
      if (resp_load) begin
        resp.mag   <= rounded[32:16];
        resp.phase <= phase_r;
      end
    end
  end

  assign RDY_request_put  = (state == GC_IDLE);
  assign RDY_response_get = (state == GC_DONE);
  assign response_get     = resp;

endmodule
